// File: rtl/tcp_tx_session_handshake.sv
// tcp_tx_session_handshake: tx handshake between the session/payload FIFOs and the TOE tx interfaces.
// Optional macro TX_STATUS_TIMEOUT_EN bounds the status wait to TIMEOUT_CYC cycles and then drains the packet.
module tcp_tx_session_handshake #(
  parameter logic [15:0] PKT_LEN     = 16'd64,
  parameter int          MAX_RETRY   = 3,
  parameter int          BACKOFF_CYC = 256,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         s_meta_valid,
  output logic         s_meta_ready,
  input  logic [15:0]  s_meta_data,
  input  logic         s_data_valid,
  output logic         s_data_ready,
  input  logic [511:0] s_data_data,
  input  logic         s_data_last,
  output logic         m_axis_tx_metadata_TVALID,
  input  logic         m_axis_tx_metadata_TREADY,
  output logic [31:0]  m_axis_tx_metadata_TDATA,
  input  logic         s_axis_tx_status_TVALID,
  output logic         s_axis_tx_status_TREADY,
  input  logic [63:0]  s_axis_tx_status_TDATA,
  output logic         m_axis_tx_data_TVALID,
  input  logic         m_axis_tx_data_TREADY,
  output logic [511:0] m_axis_tx_data_TDATA,
  output logic [63:0]  m_axis_tx_data_TKEEP,
  output logic         m_axis_tx_data_TLAST,
  output logic [31:0]  stat_sent,
  output logic [31:0]  stat_dropped,
  output logic [15:0]  stat_stray_status
);
  typedef enum logic [2:0] {IDLE, SEND_META, WAIT_STATUS, FORWARD, DRAIN, BACKOFF} state_t;
  state_t state, state_nx;
  logic [31:0] meta_data;
  logic [7:0] retry;
  logic [7:0] bo_cnt;
  logic [1:0] code;
  logic fwd, drn, last_fwd, last_drn, stray, tmo;
  logic unused_status;
  assign code = s_axis_tx_status_TDATA[63:62];
  assign unused_status = ^s_axis_tx_status_TDATA[61:0];
  assign fwd = state == FORWARD;
  assign drn = state == DRAIN;
  assign last_fwd = fwd && s_data_valid && m_axis_tx_data_TREADY && s_data_last;
  assign last_drn = drn && s_data_valid && s_data_last;
  assign stray = s_axis_tx_status_TVALID && state != WAIT_STATUS;
  assign s_meta_ready = state == IDLE;
  assign m_axis_tx_metadata_TVALID = state == SEND_META;
  assign m_axis_tx_metadata_TDATA = meta_data;
  assign s_axis_tx_status_TREADY = 1'b1;
  assign s_data_ready = fwd ? m_axis_tx_data_TREADY : drn;
  assign m_axis_tx_data_TVALID = fwd && s_data_valid;
  assign m_axis_tx_data_TDATA = fwd ? s_data_data : '0;
  assign m_axis_tx_data_TKEEP = '1;
  assign m_axis_tx_data_TLAST = s_data_last;
`ifdef TX_STATUS_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  assign tmo = state == WAIT_STATUS && tmo_cnt == 16'(TIMEOUT_CYC - 1);
  // cycles spent waiting for status; cleared whenever the wait ends
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) tmo_cnt <= '0;
    else tmo_cnt <= (state == WAIT_STATUS && state_nx == WAIT_STATUS) ? tmo_cnt + 16'd1 : '0;
`else
  assign tmo = 1'b0;
`endif
  // next-state decode; a status is only acted on while waiting for it
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        state_nx = s_meta_valid ? SEND_META : IDLE;
      SEND_META:   state_nx = m_axis_tx_metadata_TREADY ? WAIT_STATUS : SEND_META;
      WAIT_STATUS: state_nx = s_axis_tx_status_TVALID ?
                              (code == 2'd0 ? FORWARD :
                               code == 2'd1 ? DRAIN :
                               retry < 8'(MAX_RETRY) ? BACKOFF : DRAIN) :
                              (tmo ? DRAIN : WAIT_STATUS);
      BACKOFF:     state_nx = bo_cnt == 8'd0 ? SEND_META : BACKOFF;
      FORWARD:     state_nx = last_fwd ? IDLE : FORWARD;
      DRAIN:       state_nx = last_drn ? IDLE : DRAIN;
      default:     state_nx = IDLE;
    endcase
  end
  // state, latched metadata word, retry/backoff bookkeeping and statistics
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      meta_data <= '0;
      retry <= '0;
      bo_cnt <= '0;
      stat_sent <= '0;
      stat_dropped <= '0;
      stat_stray_status <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && s_meta_valid) meta_data <= {PKT_LEN, s_meta_data};
      if (last_fwd || last_drn) retry <= '0;
      else if (state == WAIT_STATUS && state_nx == BACKOFF) retry <= retry + 8'd1;
      bo_cnt <= state == BACKOFF ? bo_cnt - 8'd1 : 8'(BACKOFF_CYC - 1);
      stat_sent <= stat_sent + {31'd0, last_fwd};
      stat_dropped <= stat_dropped + {31'd0, last_drn};
      stat_stray_status <= stat_stray_status + {15'd0, stray && stat_stray_status != 16'hFFFF};
    end
endmodule

// File: tb/tb_tcp_tx_session_handshake.sv
// tb_tcp_tx_session_handshake: vector table for one clean packet plus directed multi-cycle sequences.
module tb_tcp_tx_session_handshake;
  logic aclk = 0, aresetn = 0;
  logic meta_valid = 0, meta_ready;
  logic [15:0] meta_data = 0;
  logic data_valid = 0, data_ready, data_last = 0;
  logic [511:0] data_data = 0;
  logic md_tvalid, md_tready = 0;
  logic [31:0] md_tdata;
  logic st_tvalid = 0, st_tready;
  logic [63:0] st_tdata = 0;
  logic tx_tvalid, tx_tready = 1, tx_tlast;
  logic [511:0] tx_tdata;
  logic [63:0] tx_tkeep;
  logic [31:0] stat_sent, stat_dropped;
  logic [15:0] stat_stray;
  int errors = 0, checks = 0;
  int cyc = 0, meta_cnt = 0, consumed = 0;
  int meta_t[$];
  logic [511:0] tx_q[$];

  tcp_tx_session_handshake #(.TIMEOUT_CYC(100)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_meta_valid(meta_valid), .s_meta_ready(meta_ready), .s_meta_data(meta_data),
    .s_data_valid(data_valid), .s_data_ready(data_ready), .s_data_data(data_data), .s_data_last(data_last),
    .m_axis_tx_metadata_TVALID(md_tvalid), .m_axis_tx_metadata_TREADY(md_tready), .m_axis_tx_metadata_TDATA(md_tdata),
    .s_axis_tx_status_TVALID(st_tvalid), .s_axis_tx_status_TREADY(st_tready), .s_axis_tx_status_TDATA(st_tdata),
    .m_axis_tx_data_TVALID(tx_tvalid), .m_axis_tx_data_TREADY(tx_tready), .m_axis_tx_data_TDATA(tx_tdata),
    .m_axis_tx_data_TKEEP(tx_tkeep), .m_axis_tx_data_TLAST(tx_tlast),
    .stat_sent(stat_sent), .stat_dropped(stat_dropped), .stat_stray_status(stat_stray)
  );

  always #5 aclk = ~aclk;

  // passive monitors: metadata requests with their cycle, tx beats, consumed payload beats
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (md_tvalid && md_tready) begin
      meta_cnt <= meta_cnt + 1;
      meta_t.push_back(cyc);
    end
    if (tx_tvalid && tx_tready) tx_q.push_back(tx_tdata);
    if (data_valid && data_ready) consumed <= consumed + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic start_pkt(input logic [15:0] sid);
    @(negedge aclk);
    check("idle_ready", meta_ready, 1);
    meta_valid = 1;
    meta_data = sid;
    @(negedge aclk);
    meta_valid = 0;
  endtask

  task automatic wait_meta(input int n);
    for (int i = 0; i < 3000 && meta_cnt < n; i++) @(negedge aclk);
    check("meta_wait", meta_cnt >= n, 1);
  endtask

  task automatic status(input logic [1:0] c);
    @(negedge aclk);
    st_tvalid = 1;
    st_tdata = {c, 62'h5};
    @(negedge aclk);
    st_tvalid = 0;
  endtask

  task automatic payload(input int n, input int stall_beat, input logic [511:0] base);
    logic ok, stall_ok;
    for (int b = 0; b < n; b++) begin
      @(negedge aclk);
      data_valid = 1;
      data_data = base + 512'(b);
      data_last = (b == n - 1);
      if (b == stall_beat) begin
        tx_tready = 0;
        stall_ok = 1;
        for (int k = 0; k < 10; k++) begin
          #1;
          if (data_ready || !tx_tvalid || tx_tdata !== data_data) stall_ok = 0;
          @(negedge aclk);
        end
        check("stall_hold", stall_ok, 1);
        tx_tready = 1;
      end
      ok = 0;
      for (int k = 0; k < 300; k++) begin
        #1;
        if (data_ready) begin
          ok = 1;
          break;
        end
        @(negedge aclk);
      end
      check("beat_wait", ok, 1);
    end
    @(negedge aclk);
    data_valid = 0;
    data_last = 0;
  endtask

  typedef struct {
    logic mv; logic [15:0] md; logic mtr; logic sv; logic [1:0] sc;
    logic dv; logic dl; logic ttr; logic [4:0] exp; logic [31:0] exp_md; logic [31:0] exp_sent;
  } vec_t;
  vec_t vt[8];

  initial begin
    logic [511:0] pat;
    logic ok;
    int m0, q0, c0, t0;
    pat = {16{32'hA5A5A5A5}};
    // exp = {s_meta_ready, md_tvalid, s_data_ready, tx_tvalid, tx_tlast}
    vt[0] = '{1'b1, 16'h0007, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'b10000, 32'h0, 32'd0};
    vt[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'b01000, 32'h00400007, 32'd0};
    vt[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'b01000, 32'h00400007, 32'd0};
    vt[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 5'b00001, 32'h00400007, 32'd0};
    vt[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 5'b00001, 32'h00400007, 32'd0};
    vt[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 5'b00011, 32'h00400007, 32'd0};
    vt[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 5'b00111, 32'h00400007, 32'd0};
    vt[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 5'b10000, 32'h00400007, 32'd1};
    repeat (3) @(negedge aclk);
    #1;
    check("rst_hs", {meta_ready, md_tvalid, data_ready, tx_tvalid, st_tready}, 5'b10001);
    check("rst_md", md_tdata, 0);
    check("rst_tx", tx_tdata == 512'd0, 1);
    check("rst_keep", tx_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_stats", {stat_sent, stat_dropped}, 0);
    check("rst_stray", stat_stray, 0);
    aresetn = 1;
    data_data = pat;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      meta_valid = vt[i].mv; meta_data = vt[i].md; md_tready = vt[i].mtr;
      st_tvalid = vt[i].sv; st_tdata = {vt[i].sc, 62'h123};
      data_valid = vt[i].dv; data_last = vt[i].dl; tx_tready = vt[i].ttr;
      #1;
      check($sformatf("vec%0d_hs", i), {meta_ready, md_tvalid, data_ready, tx_tvalid, tx_tlast}, vt[i].exp);
      check($sformatf("vec%0d_md", i), md_tdata, vt[i].exp_md);
      check($sformatf("vec%0d_tx", i), tx_tdata == (vt[i].exp[1] ? pat : 512'd0), 1);
      check($sformatf("vec%0d_sent", i), stat_sent, vt[i].exp_sent);
    end
    check("t1_beats", tx_q.size(), 1);
    check("t1_beat0", tx_q[0] == pat, 1);
    md_tready = 1;
    tx_tready = 1;
    // status code 1: 3 beats drained, nothing transmitted
    q0 = tx_q.size(); c0 = consumed; m0 = meta_cnt;
    start_pkt(16'h0011);
    wait_meta(m0 + 1);
    check("t2_md", md_tdata, 32'h00400011);
    status(2'd1);
    payload(3, -1, 512'h100);
    check("t2_tx", tx_q.size() - q0, 0);
    check("t2_consumed", consumed - c0, 3);
    check("t2_dropped", stat_dropped, 1);
    // four no-space statuses: three retries with backoff, then drop
    m0 = meta_cnt;
    start_pkt(16'h0022);
    for (int r = 0; r < 4; r++) begin
      wait_meta(m0 + r + 1);
      status(r[0] ? 2'd3 : 2'd2);
    end
    payload(1, -1, 512'h200);
    check("t3_reqs", meta_cnt - m0, 4);
    for (int r = 1; r < 4; r++) check($sformatf("t3_gap%0d", r), meta_t[m0 + r] - meta_t[m0 + r - 1] >= 256, 1);
    check("t3_dropped", stat_dropped, 2);
    check("t3_md", md_tdata, 32'h00400022);
    // 3-beat forward with a 10-cycle tx stall on the middle beat
    q0 = tx_q.size(); m0 = meta_cnt;
    start_pkt(16'h0033);
    wait_meta(m0 + 1);
    status(2'd0);
    payload(3, 1, 512'h300);
    check("t4_beats", tx_q.size() - q0, 3);
    ok = 1;
    for (int b = 0; b < 3; b++) if (tx_q.size() > q0 + b && tx_q[q0 + b] != 512'h300 + 512'(b)) ok = 0;
    check("t4_order", ok, 1);
    check("t4_sent", stat_sent, 2);
    // stray status in IDLE, then a stray coinciding with metadata accept
    status(2'd0);
    #1;
    check("t5_stray", stat_stray, 1);
    check("t5_idle", {meta_ready, md_tvalid}, 2'b10);
    m0 = meta_cnt; q0 = tx_q.size();
    @(negedge aclk);
    meta_valid = 1; meta_data = 16'h0044;
    @(negedge aclk);
    meta_valid = 0; st_tvalid = 1; st_tdata = {2'd1, 62'h0};
    @(negedge aclk);
    st_tvalid = 0;
    check("t5_stray2", stat_stray, 2);
    wait_meta(m0 + 1);
    status(2'd0);
    payload(1, -1, 512'h400);
    check("t5_sent", stat_sent, 3);
    check("t5_beat", tx_q.size() - q0, 1);
`ifdef TX_STATUS_TIMEOUT_EN
    m0 = meta_cnt;
    start_pkt(16'h0055);
    wait_meta(m0 + 1);
    t0 = meta_t[m0];
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge aclk);
      #1;
      if (data_ready) begin
        ok = 1;
        break;
      end
    end
    check("t6_drain", ok, 1);
    check("t6_cycles", cyc - t0, 101);
    status(2'd0);
    check("t6_stray", stat_stray, 3);
    payload(1, -1, 512'h500);
    check("t6_dropped", stat_dropped, 3);
`endif
    // reset mid-packet abandons it and clears everything
    m0 = meta_cnt;
    start_pkt(16'h0066);
    wait_meta(m0 + 1);
    status(2'd0);
    @(negedge aclk);
    data_valid = 1; data_data = 512'h600; data_last = 0;
    #1;
    check("t7_fwd", tx_tvalid, 1);
    aresetn = 0;
    #1;
    check("t7_rst_hs", {meta_ready, md_tvalid, data_ready, tx_tvalid}, 4'b1000);
    check("t7_rst_stats", {stat_sent, stat_dropped, 16'(stat_stray)}, 0);
    @(negedge aclk);
    aresetn = 1; data_valid = 0;
    @(negedge aclk);
    #1;
    check("t7_idle", {meta_ready, data_ready}, 2'b10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
